logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: Nbit, default 8, operand/result width (Nbit >= 2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  Nbit each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 operation code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths/meanings for requester 1.
REQ-009 rsp_valid  output  1  response holds a completed result.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  requester that issued the response.
REQ-012 rsp_result  output  Nbit  operation result.
REQ-013 rsp_N, rsp_Z, rsp_C, rsp_V  output  1 each  negative, zero, carry, overflow flags.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqX_valid, grant one requester; reqX_ready = (state==IDLE) && granted X, combinational; operands, op and id latched on that edge; go to EXEC.
REQ-016 Grant: only one valid -> that one; both valid -> requester named by priority pointer ptr.
REQ-017 ready SHALL never be asserted to a requester whose valid is low, nor to both in one cycle, nor outside IDLE.
REQ-018 EXEC: one cycle; compute result and flags from latched values; register into rsp_* fields; go to RESP.
REQ-019 RESP: rsp_valid=1; rsp_* stable until rsp_valid && rsp_ready; on that edge ptr <= ~rsp_id, state -> IDLE.
REQ-020 Latency: accept at edge T -> rsp_valid high from T+2; minimum 3 cycles per operation; no new acceptance while EXEC or RESP.
REQ-021 Op codes: 000 A&B; 001 A|B; 010 A^B; 011 A<<B; 100 A>>B (logical, zero-fill); 101-111 result 0, all flags 0.
REQ-022 Shift count = full Nbit-wide B value; count >= Nbit -> result 0, C=0, V=1; otherwise V=0.
REQ-023 C for shifts with 0 < count < Nbit = last bit shifted out (SHL: A[Nbit-count], SHR: A[count-1]); count 0 -> C=0, result=A; C=0 for AND/OR/XOR.
REQ-024 For codes 000-100: N = result[Nbit-1]; Z = (result == 0); V=0 for AND/OR/XOR.
REQ-025 requester inputs changing after acceptance SHALL not affect the in-flight operation.

Reset
REQ-026 rst high at an edge: state IDLE, ptr 0, rsp_valid 0, rsp_id 0, rsp_result 0, all flags 0; req ready outputs 0 while rst high.
REQ-027 rst in EXEC or RESP SHALL discard the in-flight operation; no response issued for it.
REQ-028 First acceptance possible on the first edge after rst deasserts.

Verification
REQ-029 Nbit=8, req0 op 000 A=0xF0 B=0x3C, rsp_ready=1 -> rsp_valid 2 cycles after accept, result 0x30, id 0, N0 Z0 C0 V0.
REQ-030 After reset, both valid same cycle (req0 op 001 A=0x80 B=0x01; req1 op 010 A=0x55 B=0x55) -> req0 first: 0x81 N1; then req1: 0x00 Z1, id 1.
REQ-031 Op 011 A=0x81 B=0x01 -> 0x02 C1 V0; op 100 A=0x81 B=0x08 -> 0x00 Z1 C0 V1; op 110 -> 0x00, all flags 0.
REQ-032 rsp_ready low 5 cycles with req1_valid held -> rsp_* constant, req1_ready 0 throughout; accepted immediately after handshake.
REQ-033 Both requesters continuously valid -> grants strictly alternate 0,1,0,1 over 8 responses.
REQ-034 rst pulsed one cycle while in RESP -> rsp_valid 0 next cycle, ptr 0, no response for discarded op.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Two-requester front end for a small logic/shift unit. In IDLE one pending
//   requester is granted: a lone valid wins, and when both are valid the
//   round-robin pointer decides. The operands are captured on the accept edge.
//   EXEC computes the result and flags into the response registers, and RESP
//   holds them until the consumer takes them. Each operation therefore takes
//   at least three cycles.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqX_valid / reqX_ready     request handshake (X = 0, 1); ready is combinational
//   reqX_a, reqX_b, reqX_op     operands and operation code
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_result          issuing requester and result
//   rsp_N, rsp_Z, rsp_C, rsp_V  negative, zero, carry and overflow flags
module logic_unit_arbiter #(
    parameter int Nbit = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [Nbit-1:0] req0_a,
    input  logic [Nbit-1:0] req0_b,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [Nbit-1:0] req1_a,
    input  logic [Nbit-1:0] req1_b,
    input  logic [2:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [Nbit-1:0] rsp_result,
    output logic            rsp_N,
    output logic            rsp_Z,
    output logic            rsp_C,
    output logic            rsp_V
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            id_q, id_d;
    logic [Nbit-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            rid_q, rid_d;
    logic [Nbit-1:0] res_q, res_d;
    logic            n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic            gnt0, gnt1;
    logic [Nbit-1:0] alu_res;
    logic            alu_n, alu_z, alu_c, alu_v;
    logic [Nbit:0]   shl_w, shr_w;
    logic            big_cnt;

    // When both requesters are valid, the pointer breaks the tie. The two
    // grants are mutually exclusive by construction.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || !ptr_q);
        gnt1 = req1_valid && (!req0_valid ||  ptr_q);
        req0_ready = !rst && (state_q == IDLE) && gnt0;
        req1_ready = !rst && (state_q == IDLE) && gnt1;
    end

    // Both shifts are widened by one bit. The extra bit catches the last bit
    // shifted out: bit Nbit for a left shift, bit 0 for a right shift. A
    // shift count of zero leaves that bit clear, so C is 0.
    always_comb begin
        shl_w   = {1'b0, a_q} << b_q;
        shr_w   = {a_q, 1'b0} >> b_q;
        big_cnt = (b_q >= Nbit'(Nbit));
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: alu_res = a_q ^ b_q;
            3'b011: begin
                if (big_cnt) begin
                    alu_v = 1'b1;
                end else begin
                    alu_res = shl_w[Nbit-1:0];
                    alu_c   = shl_w[Nbit];
                end
            end
            3'b100: begin
                if (big_cnt) begin
                    alu_v = 1'b1;
                end else begin
                    alu_res = shr_w[Nbit:1];
                    alu_c   = shr_w[0];
                end
            end
            default: alu_res = '0;
        endcase
        // Reserved op codes report every flag clear, Z included.
        alu_n = (op_q <= 3'b100) && alu_res[Nbit-1];
        alu_z = (op_q <= 3'b100) && (alu_res == '0);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rid_d   = rid_q;
        res_d   = res_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a  : req0_a;
                    b_d     = gnt1 ? req1_b  : req0_b;
                    op_d    = gnt1 ? req1_op : req0_op;
                    id_d    = gnt1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                n_d     = alu_n;
                z_d     = alu_z;
                c_d     = alu_c;
                v_d     = alu_v;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = ~rid_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rid_q   <= 1'b0;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rid_q   <= rid_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rid_q;
    assign rsp_result = res_q;
    assign rsp_N      = n_q;
    assign rsp_Z      = z_q;
    assign rsp_C      = c_q;
    assign rsp_V      = v_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter (Nbit = 8). Directed vectors are queued per
// requester, and the hand-computed responses go into a scoreboard queue in
// their expected order. A negedge monitor pops and compares each response
// handshake.
module tb_logic_unit_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_N, rsp_Z, rsp_C, rsp_V;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.Nbit(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_N(rsp_N), .rsp_Z(rsp_Z),
        .rsp_C(rsp_C), .rsp_V(rsp_V)
    );

    typedef struct packed { logic [2:0] op; logic [7:0] a; logic [7:0] b; } vec_t;
    typedef struct packed { logic id; logic [7:0] r; logic n, z, c, v; } rsp_t;

    vec_t q0[$];
    vec_t q1[$];
    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = -100;
    int   hs_cyc = 0;
    bit   acc0 = 0, acc1 = 0, chk_gap = 0, hs_seen = 0;
    logic prev_v = 1'b0;

    function automatic vec_t mkv(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        mkv = {op, a, b};
    endfunction

    function automatic rsp_t mke(logic id, logic [7:0] r, logic n, logic z, logic c, logic v);
        mke = {id, r, n, z, c, v};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: hold the head vector valid until it is accepted.
    initial begin
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        forever begin
            @(posedge clk);
            if (acc0) void'(q0.pop_front());
            #1;
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                {req0_op, req0_a, req0_b} = q0[0];
            end else begin
                req0_valid = 1'b0;
            end
        end
    end

    initial begin
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        forever begin
            @(posedge clk);
            if (acc1) void'(q1.pop_front());
            #1;
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                {req1_op, req1_a, req1_b} = q1[0];
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        rsp_t got;
        rsp_t e;
        chk("ready_protocol",
            {31'd0, (req0_ready && req1_ready) || (req0_ready && !req0_valid) || (req1_ready && !req1_valid)},
            32'd0);
        if (chk_gap && hs_seen && req1_valid && req1_ready) begin
            chk("accept_after_handshake", cyc - hs_cyc, 1);
            chk_gap = 0;
        end
        if (rsp_valid && !prev_v) chk("latency", cyc - acc_cyc, 2);
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (rsp_valid && rsp_ready) begin
            if (chk_gap && !hs_seen) begin
                hs_cyc  = cyc;
                hs_seen = 1;
            end
            got = {rsp_id, rsp_result, rsp_N, rsp_Z, rsp_C, rsp_V};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got %h, expected no response", got);
            end else begin
                e = exp_q.pop_front();
                chk("rsp {id,result,NZCV}", 32'(got), 32'(e));
            end
        end
        prev_v = rsp_valid;
    end

    task automatic wait_idle(int budget);
        int k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !rsp_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, k >= budget}, 32'd0);
    endtask

    task automatic wait_rsp(int budget);
        int k = 0;
        while (!rsp_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_timeout", {31'd0, k >= budget}, 32'd0);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        // Reset state; the first request is held valid during reset
        q0.push_back(mkv(3'b000, 8'hF0, 8'h3C));
        exp_q.push_back(mke(0, 8'h30, 0, 0, 0, 0));
        repeat (3) begin
            @(negedge clk);
            chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
            chk("reset_rsp", {25'd0, rsp_valid, rsp_id, rsp_result, rsp_N, rsp_Z, rsp_C, rsp_V}, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("first_accept_after_reset", {31'd0, req0_ready}, 32'd1);
        wait_idle(50);

        // Simultaneous requests after reset: requester 0 first
        pulse_rst();
        @(negedge clk);
        q0.push_back(mkv(3'b001, 8'h80, 8'h01));
        q1.push_back(mkv(3'b010, 8'h55, 8'h55));
        exp_q.push_back(mke(0, 8'h81, 1, 0, 0, 0));
        exp_q.push_back(mke(1, 8'h00, 0, 1, 0, 0));
        wait_idle(50);

        // Back-pressure: response held, requester 1 waits, then is taken at once
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        q0.push_back(mkv(3'b011, 8'h81, 8'h01));
        q1.push_back(mkv(3'b100, 8'h81, 8'h08));
        exp_q.push_back(mke(0, 8'h02, 0, 0, 1, 0));
        exp_q.push_back(mke(1, 8'h00, 0, 1, 0, 1));
        wait_rsp(20);
        repeat (5) begin
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_result", {24'd0, rsp_result}, 32'h02);
            chk("stall_id", {31'd0, rsp_id}, 32'd0);
            chk("stall_flags", {28'd0, rsp_N, rsp_Z, rsp_C, rsp_V}, 32'b0010);
            chk("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        hs_seen   = 0;
        chk_gap   = 1;
        rsp_ready = 1'b1;
        wait_idle(50);
        chk("gap_check_done", {31'd0, chk_gap}, 32'd0);

        // Reserved op code
        q0.push_back(mkv(3'b110, 8'hFF, 8'hFF));
        exp_q.push_back(mke(0, 8'h00, 0, 0, 0, 0));
        wait_idle(50);

        // Both continuously valid: strict alternation 0,1,0,1...
        pulse_rst();
        @(negedge clk);
        q0.push_back(mkv(3'b000, 8'hAA, 8'h0F));
        q0.push_back(mkv(3'b100, 8'h81, 8'h01));
        q0.push_back(mkv(3'b011, 8'h0F, 8'h07));
        q0.push_back(mkv(3'b100, 8'h81, 8'hFF));
        q1.push_back(mkv(3'b001, 8'h00, 8'h00));
        q1.push_back(mkv(3'b011, 8'h81, 8'h00));
        q1.push_back(mkv(3'b010, 8'hA5, 8'hFF));
        q1.push_back(mkv(3'b111, 8'h12, 8'h34));
        exp_q.push_back(mke(0, 8'h0A, 0, 0, 0, 0));
        exp_q.push_back(mke(1, 8'h00, 0, 1, 0, 0));
        exp_q.push_back(mke(0, 8'h40, 0, 0, 1, 0));
        exp_q.push_back(mke(1, 8'h81, 1, 0, 0, 0));
        exp_q.push_back(mke(0, 8'h80, 1, 0, 1, 0));
        exp_q.push_back(mke(1, 8'h5A, 0, 0, 0, 0));
        exp_q.push_back(mke(0, 8'h00, 0, 1, 0, 1));
        exp_q.push_back(mke(1, 8'h00, 0, 0, 0, 0));
        wait_idle(200);

        // Leave the pointer at 1, then reset mid-response
        q0.push_back(mkv(3'b001, 8'hF0, 8'h0F));
        exp_q.push_back(mke(0, 8'hFF, 1, 0, 0, 0));
        wait_idle(50);
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        q1.push_back(mkv(3'b000, 8'hFF, 8'hFF));
        wait_rsp(20);
        pulse_rst();
        @(negedge clk);
        chk("discard_valid", {31'd0, rsp_valid}, 32'd0);
        chk("discard_fields", {23'd0, rsp_id, rsp_result}, 32'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        q0.push_back(mkv(3'b010, 8'h0F, 8'hF0));
        q1.push_back(mkv(3'b000, 8'h0F, 8'hF0));
        exp_q.push_back(mke(0, 8'hFF, 1, 0, 0, 0));
        exp_q.push_back(mke(1, 8'h00, 0, 1, 0, 0));
        wait_idle(50);
        repeat (3) @(negedge clk);
        chk("no_pending", {31'd0, exp_q.size() != 0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
